// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared types and constants for the FP adder stages
package fa_pkg;

    localparam int EXP_W = 8;
    localparam int SIG_W = 24;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [30:0] INF_MAG = {EXP_MAX, 23'h0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        PACK = 2'd3
    } state_t;

endpackage

// File: rtl/fa_step2.sv
// rtl/fa_step2.sv - FP adder stage 2: significand add, iterative renormalise, IEEE-754 pack
module fa_step2
    import fa_pkg::*;
(
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_ex,
    input  logic [SIG_W-1:0] in_input1,
    input  logic [SIG_W-1:0] in_input2,
    input  logic             in_ov_yn,
    output logic             out_valid,
    output logic [31:0]      out_result,
    output logic             busy
);

    state_t           state;
    logic             sign_r;
    logic [EXP_W-1:0] ex_r;
    logic [SIG_W-1:0] in1_r;
    logic [SIG_W-1:0] in2_r;
    logic             ov_r;
    logic [SIG_W-1:0] m_r;
    logic [EXP_W-1:0] e_r;
    logic             forced_r;
    logic [31:0]      forced_val_r;

    logic [SIG_W:0]   sum;
    logic [EXP_W-1:0] ex_inc;
    logic [SIG_W-1:0] add_m;
    logic [EXP_W-1:0] add_e;
    logic             add_carry;
    logic [SIG_W-1:0] m_shl;

    assign sum       = {1'b0, in1_r} + {1'b0, in2_r};
    assign ex_inc    = ex_r + 8'd1;
    assign add_carry = ov_r & sum[SIG_W];
    assign add_m     = add_carry ? sum[SIG_W:1] : sum[SIG_W-1:0];
    assign add_e     = add_carry ? ex_inc : ex_r;
    assign m_shl     = {m_r[SIG_W-2:0], 1'b0};

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= IDLE;
            sign_r       <= 1'b0;
            ex_r         <= '0;
            in1_r        <= '0;
            in2_r        <= '0;
            ov_r         <= 1'b0;
            m_r          <= '0;
            e_r          <= '0;
            forced_r     <= 1'b0;
            forced_val_r <= POS_ZERO;
            out_valid    <= 1'b0;
            out_result   <= POS_ZERO;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= in_sign;
                        ex_r     <= in_ex;
                        in1_r    <= in_input1;
                        in2_r    <= in_input2;
                        ov_r     <= in_ov_yn;
                        forced_r <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    m_r <= add_m;
                    e_r <= add_e;
                    if (add_carry && ex_inc == EXP_MAX) begin
                        forced_r     <= 1'b1;
                        forced_val_r <= {sign_r, INF_MAG};
                        state        <= PACK;
                    end else if (add_m == '0) begin
                        forced_r     <= 1'b1;
                        forced_val_r <= POS_ZERO;
                        state        <= PACK;
                    end else if (add_m[SIG_W-1]) begin
                        state <= PACK;
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (m_r[SIG_W-1]) begin
                        state <= PACK;
                    end else if (e_r > 8'd1) begin
                        // leave as soon as the shifted value is normalised so n shifts cost n cycles
                        m_r <= m_shl;
                        e_r <= e_r - 8'd1;
                        if (m_shl[SIG_W-1])
                            state <= PACK;
                    end else begin
                        forced_r     <= 1'b1;
                        forced_val_r <= {sign_r, 31'h0};
                        state        <= PACK;
                    end
                end
                PACK: begin
                    out_result <= forced_r ? forced_val_r : {sign_r, e_r, m_r[SIG_W-2:0]};
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_step2.sv
// tb/tb_fa_step2.sv - directed vector bench for fa_step2
module tb_fa_step2;

    logic        CLK;
    logic        RESETn;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_ex;
    logic [23:0] in_input1;
    logic [23:0] in_input2;
    logic        in_ov_yn;
    logic        out_valid;
    logic [31:0] out_result;
    logic        busy;

    int total;
    int bad;

    fa_step2 dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_ex     (in_ex),
        .in_input1 (in_input1),
        .in_input2 (in_input2),
        .in_ov_yn  (in_ov_yn),
        .out_valid (out_valid),
        .out_result(out_result),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  ex;
        logic [23:0] in1;
        logic [23:0] in2;
        logic        ov;
        logic [31:0] exp_result;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] a,
                         input logic [23:0] b, input logic ov);
        in_sign   = s;
        in_ex     = e;
        in_input1 = a;
        in_input2 = b;
        in_ov_yn  = ov;
    endtask

    task automatic run_vec(input vec_t v);
        int  lat;
        bit  got;
        drive(v.sign, v.ex, v.in1, v.in2, v.ov);
        in_valid = 1'b1;
        chk({v.name, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({v.name, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk({v.name, "_strobe"}, 32'(got), 32'd1);
        chk({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, "_result"}, out_result, v.exp_result);
        tick();
        chk({v.name, "_strobe_end"}, 32'(out_valid), 32'd0);
        chk({v.name, "_hold"}, out_result, v.exp_result);
    endtask

    initial begin
        int strobes;
        logic [31:0] res0;
        logic [31:0] res1;

        total = 0;
        bad   = 0;
        RESETn   = 1'b0;
        in_valid = 1'b0;
        drive(1'b0, 8'd0, 24'd0, 24'd0, 1'b0);

        vecs[0]  = '{"one_plus_one",  1'b0, 8'd127, 24'h800000, 24'h800000, 1'b1, 32'h40000000, 2};
        vecs[1]  = '{"onep5_minus_1", 1'b0, 8'd127, 24'h800000, 24'hC00000, 1'b0, 32'h3F000000, 3};
        vecs[2]  = '{"one_minus_one", 1'b0, 8'd127, 24'h800000, 24'h800000, 1'b0, 32'h00000000, 2};
        vecs[3]  = '{"overflow_inf",  1'b1, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 32'hFF800000, 2};
        vecs[4]  = '{"flush_neg",     1'b1, 8'd2,   24'h000001, 24'h000000, 1'b0, 32'h80000000, 4};
        vecs[5]  = '{"neg_two",       1'b1, 8'd127, 24'h800000, 24'h800000, 1'b1, 32'hC0000000, 2};
        vecs[6]  = '{"ov_no_carry",   1'b0, 8'd130, 24'h400000, 24'h200000, 1'b1, 32'h40C00000, 3};
        vecs[7]  = '{"carry_dropped", 1'b0, 8'd100, 24'hC00000, 24'hC00000, 1'b0, 32'h32000000, 2};
        vecs[8]  = '{"shift19",       1'b0, 8'd127, 24'h000010, 24'h000000, 1'b0, 32'h36000000, 21};
        vecs[9]  = '{"flush_after4",  1'b0, 8'd5,   24'h000001, 24'h000000, 1'b0, 32'h00000000, 7};
        vecs[10] = '{"zero_ov",       1'b1, 8'd50,  24'h000000, 24'h000000, 1'b1, 32'h00000000, 2};

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        RESETn = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // in_valid while busy must be ignored
        drive(1'b0, 8'd127, 24'h800000, 24'h800000, 1'b1);
        in_valid = 1'b1;
        tick();
        drive(1'b1, 8'd10, 24'h000001, 24'h000001, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("busy_ignore_valid", 32'(out_valid), 32'd1);
        chk("busy_ignore_result", out_result, 32'h40000000);
        tick();

        // reset mid-NORM
        drive(1'b0, 8'd127, 24'h000010, 24'h000000, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        RESETn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_result", out_result, 32'h0);
        tick();
        RESETn = 1'b1;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) strobes++;
        end
        chk("midrst_no_strobe", 32'(strobes), 32'd0);
        chk("midrst_idle_ready", 32'(in_ready), 32'd1);

        // back-to-back: second accept in the out_valid cycle
        drive(1'b0, 8'd127, 24'h800000, 24'h800000, 1'b1);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("b2b_first_strobe", 32'(out_valid), 32'd1);
        chk("b2b_ready_in_strobe", 32'(in_ready), 32'd1);
        res0 = out_result;
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accepted", 32'(busy), 32'd1);
        strobes = 0;
        res1 = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) begin
                strobes++;
                res1 = out_result;
            end
        end
        chk("b2b_first_result", res0, 32'h40000000);
        chk("b2b_second_count", 32'(strobes), 32'd1);
        chk("b2b_second_result", res1, 32'h40000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
